// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// Shared MIPS definitions: opcode and ALU codes used by control, fetch FSM states, default reset PC.
package mips_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] ALU_AND = 4'h0;
   localparam logic [3:0] ALU_OR  = 4'h1;
   localparam logic [3:0] ALU_ADD = 4'h2;
   localparam logic [3:0] ALU_SUB = 4'h6;
   localparam logic [3:0] ALU_SLT = 4'h7;
   localparam logic [3:0] ALU_NOR = 4'hC;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_REQ   = 2'd1,
      FETCH_VALID = 2'd2
   } fetch_state_t;

   function automatic logic signed [31:0] sign_ext16(input logic [15:0] imm);
      return $signed({{16{imm[15]}}, imm});
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
`timescale 1ns/1ps
// Combinational next-PC selection: sequential, branch-relative, or pseudo-direct jump.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [25:0] target_imm,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   logic signed [31:0] branch_offset;
   logic        [31:0] branch_target;
   logic        [31:0] jump_target;

   assign pc_plus4      = pc + 32'd4;
   assign branch_offset = sign_ext16(target_imm[15:0]) <<< 2;
   assign branch_target = pc_plus4 + $unsigned(branch_offset);
   assign jump_target   = {pc_plus4[31:28], target_imm, 2'b00};

   // Jump outranks a taken branch when control raises both
   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = jump_target;
      else if (branch && zero)
         next_pc = branch_target;
   end

endmodule

// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// Program counter and instruction fetch over a req/ack memory handshake; holds the word until retired.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic        CLK,
   input  logic        Reset_L,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction,
   output logic [5:0]  Opcode,
   output logic        InstrValid,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   input  logic        Advance,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  instr;
   logic         instr_valid;
   logic         mem_req;
   logic [31:0]  next_pc;
   logic [31:0]  pc_plus4;

   next_pc_calc u_next_pc (
      .pc         (pc),
      .target_imm (instr[25:0]),
      .branch     (Branch),
      .jump       (Jump),
      .zero       (Zero),
      .pc_plus4   (pc_plus4),
      .next_pc    (next_pc)
   );

   // Request is raised on entry to FETCH and dropped on the ack edge, so it is a clean register
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state       <= FETCH_IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         mem_req     <= 1'b0;
      end else begin
         case (state)
            FETCH_IDLE: begin
               state   <= FETCH_REQ;
               mem_req <= 1'b1;
            end
            FETCH_REQ: begin
               if (IMemAck) begin
                  instr       <= IMemData;
                  instr_valid <= 1'b1;
                  mem_req     <= 1'b0;
                  state       <= FETCH_VALID;
               end
            end
            FETCH_VALID: begin
               if (Advance) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  mem_req     <= 1'b1;
                  state       <= FETCH_REQ;
               end
            end
            default: begin
               state   <= FETCH_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign IMemReq     = mem_req;
   assign IMemAddr    = pc;
   assign PC          = pc;
   assign PCPlus4     = pc_plus4;
   assign Instruction = instr;
   assign Opcode      = instr[31:26];
   assign InstrValid  = instr_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Directed and randomized bench for instruction_fetch against a transaction-level PC model.
module tb_instruction_fetch;
   import mips_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        Reset_L = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck = 1'b0;
   logic [31:0] IMemData = '0;
   logic [31:0] Instruction;
   logic [5:0]  Opcode;
   logic        InstrValid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        Advance = 1'b0;
   logic        Branch = 1'b0;
   logic        Jump = 1'b0;
   logic        Zero = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   always #5 CLK = ~CLK;

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .CLK         (CLK),
      .Reset_L     (Reset_L),
      .IMemReq     (IMemReq),
      .IMemAddr    (IMemAddr),
      .IMemAck     (IMemAck),
      .IMemData    (IMemData),
      .Instruction (Instruction),
      .Opcode      (Opcode),
      .InstrValid  (InstrValid),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .Advance     (Advance),
      .Branch      (Branch),
      .Jump        (Jump),
      .Zero        (Zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Architectural next-PC rule written with plain arithmetic
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                            input bit br, input bit jp, input bit z);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (br && z) begin
         off = int'(ins[15:0]);
         if (off >= 32768) off = off - 65536;
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   // Called one step after an edge with the DUT in FETCH
   task automatic do_fetch(input int wait_n, input logic [31:0] word, input bit stray);
      for (int i = 0; i < wait_n; i++) begin
         chk1("req_wait", IMemReq, 1'b1);
         chk("addr_wait", IMemAddr, m_pc);
         IMemAck  = 1'b0;
         IMemData = $urandom;
         Advance  = stray;
         Jump     = stray;
         tick();
      end
      chk1("req", IMemReq, 1'b1);
      chk("addr", IMemAddr, m_pc);
      IMemAck  = 1'b1;
      IMemData = word;
      Advance  = 1'b0;
      Jump     = 1'b0;
      tick();
      IMemAck  = 1'b0;
      IMemData = $urandom;
      m_instr  = word;
      chk1("valid", InstrValid, 1'b1);
      chk("instr", Instruction, word);
      chk("opcode", {26'b0, Opcode}, {26'b0, word[31:26]});
      chk1("req_low", IMemReq, 1'b0);
      chk("pc", PC, m_pc);
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
   endtask

   // Called one step after an edge with the DUT in VALID
   task automatic do_retire(input int stall, input bit br, input bit jp, input bit z);
      logic [31:0] exp;
      for (int i = 0; i < stall; i++) begin
         chk1("stall_valid", InstrValid, 1'b1);
         chk("stall_instr", Instruction, m_instr);
         chk("stall_pc", PC, m_pc);
         chk1("stall_req", IMemReq, 1'b0);
         IMemAck  = 1'b1;
         IMemData = ~m_instr;
         Advance  = 1'b0;
         Branch   = 1'($urandom);
         Jump     = 1'($urandom);
         Zero     = 1'($urandom);
         tick();
      end
      IMemAck = 1'b0;
      Advance = 1'b1;
      Branch  = br;
      Jump    = jp;
      Zero    = z;
      exp = ref_next(m_pc, m_instr, br, jp, z);
      tick();
      Advance = 1'b0;
      Branch  = 1'b0;
      Jump    = 1'b0;
      Zero    = 1'b0;
      m_pc    = exp;
      chk1("ret_valid", InstrValid, 1'b0);
      chk1("ret_req", IMemReq, 1'b1);
      chk("ret_addr", IMemAddr, exp);
      chk("ret_pcplus4", PCPlus4, exp + 32'd4);
   endtask

   initial begin
      logic [31:0] w;
      int          wn;
      int          sn;
      bit          rb;
      bit          rj;
      bit          rz;

      // Reset values
      #2;
      chk1("rst_req", IMemReq, 1'b0);
      chk1("rst_valid", InstrValid, 1'b0);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_opcode", {26'b0, Opcode}, 32'h0);
      chk("rst_pc", PC, RST_PC);
      chk("rst_addr", IMemAddr, RST_PC);
      chk("rst_pcplus4", PCPlus4, RST_PC + 32'd4);
      tick();
      tick();
      Reset_L = 1'b1;
      chk1("idle_req", IMemReq, 1'b0);
      tick();
      m_pc = RST_PC;
      chk1("first_req", IMemReq, 1'b1);

      // Sequential fetch, zero-wait ack, immediate retire
      do_fetch(0, 32'h0000_0020, 1'b0);
      do_retire(0, 1'b0, 1'b0, 1'b0);
      chk("seq_addr1", IMemAddr, 32'h4);
      do_fetch(0, 32'h0122_4020, 1'b0);
      do_retire(0, 1'b0, 1'b0, 1'b0);
      chk("seq_addr2", IMemAddr, 32'h8);

      // Wait states with stray Advance/Jump during FETCH, then jump to 0x100
      do_fetch(3, {OP_J, 26'h000_0040}, 1'b1);
      do_retire(0, 1'b0, 1'b1, 1'b0);
      chk("jmp_0x100", IMemAddr, 32'h100);

      // beq taken then not taken from 0x100
      do_fetch(1, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 1'b0);
      do_retire(0, 1'b1, 1'b0, 1'b1);
      chk("beq_taken", IMemAddr, 32'h0FC);
      do_fetch(0, 32'h0, 1'b0);
      do_retire(0, 1'b0, 1'b0, 1'b0);
      do_fetch(0, {OP_BEQ, 5'd1, 5'd2, 16'hFFFE}, 1'b0);
      do_retire(0, 1'b1, 1'b0, 1'b0);
      chk("beq_not_taken", IMemAddr, 32'h104);

      // Reach 0x1000_0000, then jump with branch and zero also raised
      do_fetch(0, {OP_J, 26'h3FF_FFFF}, 1'b0);
      do_retire(0, 1'b0, 1'b1, 1'b0);
      chk("jmp_top", IMemAddr, 32'h0FFF_FFFC);
      do_fetch(0, 32'h0, 1'b0);
      do_retire(0, 1'b0, 1'b0, 1'b0);
      chk("region1", PC, 32'h1000_0000);
      do_fetch(2, {OP_J, 26'h000_0040}, 1'b0);
      do_retire(1, 1'b1, 1'b1, 1'b1);
      chk("jump_prio", PC, 32'h1000_0100);

      // Async reset while IMemReq is high, then stray ack after release
      tick();
      #1;
      Reset_L = 1'b0;
      #1;
      chk1("arst_req", IMemReq, 1'b0);
      chk("arst_pc", PC, RST_PC);
      chk1("arst_valid", InstrValid, 1'b0);
      chk("arst_instr", Instruction, 32'h0);
      tick();
      Reset_L  = 1'b1;
      IMemAck  = 1'b1;
      IMemData = 32'hDEAD_BEEF;
      tick();
      IMemAck = 1'b0;
      m_pc = RST_PC;
      chk1("stray_valid", InstrValid, 1'b0);
      chk("stray_instr", Instruction, 32'h0);
      chk1("restart_req", IMemReq, 1'b1);
      chk("restart_addr", IMemAddr, RST_PC);

      // Branch back to 0xFFFF_FFFC, stall there, then wrap to 0
      do_fetch(0, {OP_BEQ, 5'd0, 5'd0, 16'hFFFE}, 1'b0);
      do_retire(0, 1'b1, 1'b0, 1'b1);
      chk("wrap_pc", PC, 32'hFFFF_FFFC);
      do_fetch(0, 32'h8C43_0004, 1'b0);
      chk("wrap_pcplus4", PCPlus4, 32'h0);
      do_retire(5, 1'b0, 1'b0, 1'b0);
      chk("wrap_addr", IMemAddr, 32'h0);

      // Randomized traffic against the reference rule
      for (int k = 0; k < 30; k++) begin
         w  = $urandom;
         wn = int'($urandom_range(0, 3));
         sn = int'($urandom_range(0, 2));
         rb = 1'($urandom);
         rj = ($urandom_range(0, 3) == 0);
         rz = 1'($urandom);
         do_fetch(wn, w, 1'($urandom));
         do_retire(sn, rb, rj, rz);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
